// File: rtl/display_pkg.sv
// Shared widths, segment type and field helper for the
// display path (motion-detector display_data -> scanned digits).
package display_pkg;

    localparam int DIGITS    = 3;
    localparam int SEG_W     = 7;
    localparam int DISPLAY_W = DIGITS * SEG_W;

    typedef logic [SEG_W-1:0] seg_t;

    function automatic seg_t seg_field(
        input logic [DISPLAY_W-1:0] data,
        input logic [1:0]           i
    );
        return data[SEG_W*i +: SEG_W];
    endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Slot/digit timebase: owns the slot counter and digit index and
// reports wraps plus the next-cycle digit and dead-gap status.
module scan_slot_timer
    import display_pkg::*;
#(
    parameter int SLOT_CYCLES = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] dig_nxt,
    output logic       slot_wrap,
    output logic       frame_wrap,
    output logic       in_dead
);

    localparam int CW = $clog2(SLOT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;

    always_comb begin
        slot_wrap  = (cnt_q == CW'(SLOT_CYCLES - 1));
        frame_wrap = slot_wrap && (dig_q == 2'(DIGITS - 1));
        cnt_d      = slot_wrap ? '0 : cnt_q + 1'b1;
        dig_d      = dig_q;
        if (slot_wrap) begin
            dig_d = frame_wrap ? 2'd0 : dig_q + 2'd1;
        end
        // Decoded from next state so registered outputs line up with cnt/dig
        dig_nxt = dig_d;
        in_dead = (cnt_d < CW'(DEAD_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            dig_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Frame-snapshotted 3-digit segment scanner with dead gaps between
// slots and an optional frame-synchronous blink.
module seven_seg_scanner
    import display_pkg::*;
#(
    parameter int SLOT_CYCLES  = 50000,
    parameter int DEAD_CYCLES  = 500,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DISPLAY_W-1:0] display_data,
    input  logic                 blink_en,
    output logic [SEG_W-1:0]     seg_out,
    output logic [DIGITS-1:0]    digit_en,
    output logic                 frame_done
);

    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [1:0] dig_nxt;
    logic       slot_wrap, frame_wrap, in_dead, frame_edge, active;

    logic [DISPLAY_W-1:0] snap_q, snap_d;
    logic                 blink_req_q, blink_req_d;
    logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
    logic                 blink_off_q, blink_off_d;
    logic                 frame_done_q, frame_done_d;
    seg_t                 seg_q, seg_d, seg_raw;
    logic [DIGITS-1:0]    den_q, den_d, den_raw;

    scan_slot_timer #(
        .SLOT_CYCLES(SLOT_CYCLES),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .dig_nxt   (dig_nxt),
        .slot_wrap (slot_wrap),
        .frame_wrap(frame_wrap),
        .in_dead   (in_dead)
    );

    assign frame_edge = slot_wrap && frame_wrap;

    always_comb begin
        snap_d       = snap_q;
        blink_req_d  = blink_req_q;
        blink_cnt_d  = blink_cnt_q;
        blink_off_d  = blink_off_q;
        frame_done_d = frame_edge;
        if (frame_edge) begin
            snap_d      = display_data;
            blink_req_d = blink_en;
            if (!blink_en) begin
                blink_cnt_d = '0;
                blink_off_d = 1'b0;
            end else if (blink_req_q) begin
                if (blink_cnt_q + 1'b1 == BW'(BLINK_FRAMES)) begin
                    blink_cnt_d = '0;
                    blink_off_d = ~blink_off_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
        end
        active  = !in_dead && !blink_off_d;
        seg_raw = active ? seg_field(snap_d, dig_nxt) : '0;
        den_raw = active ? (DIGITS'(1) << dig_nxt) : '0;
        seg_d   = ACTIVE_LOW ? ~seg_raw : seg_raw;
        den_d   = ACTIVE_LOW ? ~den_raw : den_raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q       <= '0;
            blink_req_q  <= 1'b0;
            blink_cnt_q  <= '0;
            blink_off_q  <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= ACTIVE_LOW ? '1 : '0;
            den_q        <= ACTIVE_LOW ? '1 : '0;
        end else begin
            snap_q       <= snap_d;
            blink_req_q  <= blink_req_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_off_q  <= blink_off_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            den_q        <= den_d;
        end
    end

    assign seg_out    = seg_q;
    assign digit_en   = den_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a cycle-level scoreboard.
module tb_seven_seg_scanner;

    localparam int SLOT  = 8;
    localparam int DEAD  = 2;
    localparam int BF    = 2;
    localparam int FRAME = 3 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [20:0] display_data = '0;
    logic        blink_en = 1'b0;
    logic [6:0]  seg_out;
    logic [2:0]  digit_en;
    logic        frame_done;

    seven_seg_scanner #(
        .SLOT_CYCLES (SLOT),
        .DEAD_CYCLES (DEAD),
        .BLINK_FRAMES(BF),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .display_data(display_data),
        .blink_en    (blink_en),
        .seg_out     (seg_out),
        .digit_en    (digit_en),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] de;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          t = 0;
    int          fstart = 0;
    logic [20:0] snap_m = '0;
    logic        blink_m = 1'b0;

    function automatic exp_t model(input int tc);
        exp_t        e;
        int          slot, c;
        logic        off, lit;
        logic [20:0] sh;
        slot = (tc / SLOT) % 3;
        c    = tc % SLOT;
        off  = blink_m && ((((tc / FRAME) - fstart) / BF) % 2 == 1);
        lit  = (c >= DEAD) && !off;
        sh   = snap_m >> (7 * slot);
        e.de  = lit ? ~(3'b001 << slot) : 3'b111;
        e.seg = lit ? ~sh[6:0] : 7'h7F;
        e.fd  = (tc > 0) && (tc % FRAME == 0);
        return e;
    endfunction

    task automatic step();
        exp_t e;
        if (rst) begin
            t       = 0;
            snap_m  = '0;
            blink_m = 1'b0;
            fstart  = 0;
            e.de    = 3'b111;
            e.seg   = 7'h7F;
            e.fd    = 1'b0;
        end else begin
            t++;
            if (t % FRAME == 0) begin
                snap_m = display_data;
                if (blink_en && !blink_m) fstart = t / FRAME;
                blink_m = blink_en;
            end
            e = model(t);
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        assert (digit_en === e.de) else begin
            errors++;
            $error("FAIL digit_en t=%0d got=%b exp=%b", t, digit_en, e.de);
        end
        checks++;
        assert (seg_out === e.seg) else begin
            errors++;
            $error("FAIL seg_out t=%0d got=%h exp=%h", t, seg_out, e.seg);
        end
        checks++;
        assert (frame_done === e.fd) else begin
            errors++;
            $error("FAIL frame_done t=%0d got=%b exp=%b", t, frame_done, e.fd);
        end
        checks++;
        assert ($countones(~digit_en) <= 1) else begin
            errors++;
            $error("FAIL onehot t=%0d got=%b exp=at_most_one_low", t, digit_en);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(input int m);
        for (int i = 0; i < FRAME && (t % FRAME) != m; i++) step();
    endtask

    initial begin
        display_data = 21'($urandom);
        run(3);
        rst = 1'b0;
        display_data = {7'h06, 7'h5B, 7'h4F};
        run(2 * FRAME);

        run_until(12);
        display_data = '0;
        run(FRAME + FRAME / 2);

        display_data = {7'h06, 7'h5B, 7'h4F};
        blink_en = 1'b1;
        run(6 * FRAME);
        blink_en = 1'b0;
        run(2 * FRAME);

        run_until(12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(FRAME + 6);

        for (int f = 0; f < 10; f++) begin
            display_data = 21'($urandom);
            run(FRAME);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Display-side consumer of the motion-detector's 21-bit `display_data` bus: three 7-bit segment patterns. It drives a time-multiplexed 3-digit common-segment display. The block snapshots the bus once per frame to prevent tearing and scans the digits with a dead gap between slots to suppress ghosting. An optional frame-synchronous blink lets the alarm path flash the display. It sits between the PIR controller's `display_data` output and the board-level segment and digit pins.

## Interface
- `SLOT_CYCLES`, 50000, clock cycles per digit slot; must be ≥ 2.
- `DEAD_CYCLES`, 500, cycles at the start of each slot with all digits disabled; 1 ≤ DEAD_CYCLES < SLOT_CYCLES.
- `BLINK_FRAMES`, 64, frames per blink half-period; ≥ 1.
- `ACTIVE_LOW`, 1, polarity of `seg_out` and `digit_en`: 1 = low-true, 0 = high-true.

- `clk` in 1: single clock. Everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `display_data` in 21: digit 0 = [6:0], digit 1 = [13:7], digit 2 = [20:14]. Bit = 1 means the segment is lit.
- `blink_en` in 1: request display flashing. Sampled at frame boundaries only.
- `seg_out` out 7: segment drive for the currently enabled digit, with `ACTIVE_LOW` applied.
- `digit_en` out 3: one-hot digit enable, with `ACTIVE_LOW` applied; bit i enables digit i.
- `frame_done` out 1: one-cycle pulse at each frame boundary.

## Operation
- State: slot counter `cnt` (0..SLOT_CYCLES-1), digit index `dig` (0..2), 21-bit `snap`, blink frame counter, `blink_off` phase bit, sampled `blink_q`.
- `cnt` increments every cycle. At `cnt==SLOT_CYCLES-1` it wraps to 0 and `dig` advances 0→1→2→0.
- Frame boundary is the edge where `cnt` wraps and `dig==2`. At that edge:
  - `snap` ← `display_data`;
  - `blink_q` ← `blink_en`;
  - `frame_done` is asserted for exactly the following cycle.
- Blink:
  - While `blink_q==0`: frame counter = 0 and `blink_off` = 0.
  - While `blink_q==1`: frame counter counts frames. After BLINK_FRAMES frames it clears and toggles `blink_off`.
  - `blink_off` changes only at frame boundaries.
- Digit i is "active" when `dig==i`, `cnt ≥ DEAD_CYCLES`, and `blink_off==0`.
  - Active: `digit_en` bit i asserts and `seg_out` = `snap` field i, both with polarity applied.
  - Otherwise: all digits inactive and `seg_out` all-inactive.
- Outputs are registered. They are decoded from the next-state values so they align with `cnt`/`dig` in the same cycle, with no extra lag.
- Polarity: when `ACTIVE_LOW=1`, an inactive output is 1 and a lit segment drives 0.

## Timing
- Reset values, in the cycle after an `rst` edge:
  - `cnt`=0, `dig`=0, `snap`=0, blink counter=0, `blink_off`=0, `blink_q`=0;
  - `frame_done`=0;
  - `digit_en` all inactive (3'b111 when low-true);
  - `seg_out` all inactive (7'h7F when low-true).
- `rst` wins over every other event, including mid-slot and at a frame boundary.
- The first frame after reset displays `snap`=0, i.e. blank. The first real data appears in frame 2.
- Frame length is 3·SLOT_CYCLES cycles.
- Every slot begins with exactly DEAD_CYCLES cycles with no digit enabled. Two digits are never enabled in the same cycle.
- A `display_data` change becomes visible at the next frame boundary, then during the next slot's active window: latency ≤ 3·SLOT_CYCLES + DEAD_CYCLES cycles.
- A `blink_en` change is observed at the next frame boundary. `blink_en` deassertion restores display from that boundary.
- Counter widths: `$clog2(SLOT_CYCLES)` and `$clog2(BLINK_FRAMES+1)`. No overflow is possible.

## Structure
- Shared package `display_pkg`:
  - `DIGITS`=3, `SEG_W`=7, `DISPLAY_W`=21;
  - `seg_t` (7-bit) typedef;
  - function `seg_field(data, i)` returning bits [7i+6:7i].
- One natural sub-module, `scan_slot_timer`. It owns `cnt`/`dig` and emits `slot_wrap`, `frame_wrap`, `in_dead`.
- The top level holds the snapshot, the blink logic, and the output registers.

## Test plan
Use SLOT_CYCLES=8, DEAD_CYCLES=2, BLINK_FRAMES=2, ACTIVE_LOW=1.

1. **Reset:** hold `rst` 3 cycles with random `display_data` → `digit_en`=3'b111, `seg_out`=7'h7F, `frame_done`=0 throughout and on the first cycle after release.
2. **Scan order:** `display_data`={7'h06,7'h5B,7'h4F}.
   - `frame_done` pulses at cycle 24 after reset.
   - Frame 2, cycles 2–7 of slot 0: `digit_en`=3'b110, `seg_out`=7'h30.
   - Slot 1: 3'b101 / 7'h24.
   - Slot 2: 3'b011 / 7'h79.
3. **Snapshot:** change `display_data` to 0 during slot 1 of a frame → slots 1–2 still show the old patterns. From the next frame, all digits show 7'h7F while enabled.
4. **Blink:** `blink_en`=1 → 2 frames lit, 2 frames with `digit_en`=3'b111 throughout, repeating. Drop `blink_en` → lit from the next frame boundary.
5. **Mid-slot reset:** assert `rst` during digit 1's active window → the next cycle shows all inactive, and scanning restarts at digit 0, `cnt`=0, with a blank frame.
6. **Dead gap:** over 10 frames, check that no cycle has more than one digit enabled. Each slot's first 2 cycles have `digit_en`=3'b111.
